data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_pkg.sv | 12 +
 rtl/data_memory_init_seq.sv | 36 +++
 rtl/data_memory_ctrl.sv | 99 +++++++++
 tb/tb_data_memory_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared state encoding and fill-mode constants
package data_memory_pkg;

   // FSM encoding: INIT fills the array, RUN serves requests
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Post-reset fill pattern selectors
   localparam int INIT_ZERO  = 0;
   localparam int INIT_INDEX = 1;

endpackage

// File: rtl/data_memory_init_seq.sv
// rtl/data_memory_init_seq.sv - post-reset fill counter and INIT/RUN sequencer
module data_memory_init_seq
   import data_memory_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   output logic             fill_en,
   output logic [IDX_W-1:0] fill_idx,
   output logic             done
);

   logic [0:0]       r_state;
   logic [IDX_W-1:0] r_idx;

   // Walk the index once through every word, then park in RUN until reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_INIT;
         r_idx   <= '0;
      end else if (r_state == ST_INIT) begin
         if (r_idx == IDX_W'(DEPTH - 1)) begin
            r_state <= ST_RUN;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign fill_en  = (r_state == ST_INIT);
   assign fill_idx = r_idx;
   assign done     = (r_state == ST_RUN);

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-enabled word memory with self-fill and checked access
module data_memory_ctrl
   import data_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int INIT_MODE  = INIT_INDEX
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    mem_write,
   input  logic                    mem_read,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   write_data,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    read_valid,
   output logic                    ready,
   output logic                    error
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_read_valid;
   logic                  r_error;

   logic                  w_fill_en;
   logic [IDX_W-1:0]      w_fill_idx;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_fill_word;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_misaligned;
   logic                  w_out_of_range;
   logic                  w_bad;
   logic                  w_req;

   data_memory_init_seq #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_init_seq (
      .clock    (clock),
      .reset    (reset),
      .fill_en  (w_fill_en),
      .fill_idx (w_fill_idx),
      .done     (w_done)
   );

   assign w_fill_word    = (INIT_MODE == INIT_INDEX) ? DATA_WIDTH'(w_fill_idx) : '0;
   assign w_idx          = IDX_W'(address >> OFF_W);
   assign w_misaligned   = (address & OFF_MASK) != '0;
   // Any bit above the index field means the address lies past the array
   assign w_out_of_range = (address >> (OFF_W + IDX_W)) != '0;
   assign w_bad          = w_misaligned | w_out_of_range;
   // Requests only count once the fill has completed
   assign w_req          = w_done & (mem_write | mem_read);

   // Array update: the fill owns the port during INIT, byte-merged writes in RUN
   always_ff @(posedge clock) begin
      if (w_fill_en) begin
         r_mem[w_fill_idx] <= w_fill_word;
      end else if (w_done && mem_write && !w_bad) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_en[b]) begin
               r_mem[w_idx][8*b +: 8] <= write_data[8*b +: 8];
            end
         end
      end
   end

   // Read data and one-cycle status pulses; a write in the same cycle wins over the read
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_result     <= '0;
         r_read_valid <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_read_valid <= 1'b0;
         r_error      <= 1'b0;
         if (w_req && w_bad) begin
            r_error <= 1'b1;
         end else if (w_req && mem_read && !mem_write) begin
            r_result     <= r_mem[w_idx];
            r_read_valid <= 1'b1;
         end
      end
   end

   assign result     = r_result;
   assign read_valid = r_read_valid;
   assign error      = r_error;
   assign ready      = w_done;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_write = 1'b0;
   logic        mem_read = 1'b0;
   logic [3:0]  byte_en = 4'h0;
   logic [31:0] address = 32'h0;
   logic [31:0] write_data = 32'h0;
   logic [31:0] result;
   logic        read_valid;
   logic        ready;
   logic        error;

   int total = 0;
   int bad = 0;

   // Reference: plain word array plus last returned read value
   logic [31:0] model_mem [32];
   logic [31:0] model_res = 32'h0;

   data_memory_ctrl #(
      .DATA_WIDTH (32),
      .DEPTH      (32),
      .ADDR_WIDTH (32),
      .INIT_MODE  (1)
   ) dut (
      .clock      (clk),
      .reset      (rst),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .byte_en    (byte_en),
      .address    (address),
      .write_data (write_data),
      .result     (result),
      .read_valid (read_valid),
      .ready      (ready),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_write = 1'b0;
      mem_read  = 1'b0;
   endtask

   task automatic drive(input bit wr, input bit rd, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
      mem_write  = wr;
      mem_read   = rd;
      byte_en    = be;
      address    = a;
      write_data = d;
   endtask

   // Apply the access rules to the model; returns expected pulses
   task automatic model_req(input bit wr, input bit rd, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d,
                            output bit e_rv, output bit e_err);
      bit rejected;
      logic [31:0] w;
      rejected = (a % 4 != 0) || (a >= 32'd128);
      e_err = (wr || rd) && rejected;
      e_rv  = rd && !wr && !rejected;
      if (wr && !rejected) begin
         w = model_mem[a / 4];
         for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
         model_mem[a / 4] = w;
      end
      if (e_rv) model_res = model_mem[a / 4];
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 3))
         0, 1: a = 32'($urandom_range(0, 31)) * 4;
         2:    a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
         default: a = $urandom | 32'h80;
      endcase
      return a;
   endfunction

   // Runs the fill after reset release; optionally throws requests at it
   task automatic run_fill(input bit noisy, output int n, output bit err_seen, output bit rv_seen);
      n = 0;
      err_seen = 1'b0;
      rv_seen = 1'b0;
      while (!ready && n < 200) begin
         if (noisy) drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          4'($urandom), rand_addr(), $urandom);
         step();
         n++;
         if (error) err_seen = 1'b1;
         if (read_valid) rv_seen = 1'b1;
      end
      idle();
      for (int i = 0; i < 32; i++) model_mem[i] = 32'(i);
      model_res = result;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
      total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", read_valid); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
   endtask

   task automatic test_init_fill();
      int n; bit es; bit rs;
      rst = 1'b0;
      run_fill(1'b0, n, es, rs);
      total++; if (n !== 32) begin bad++; $display("FAIL fill_cycles got=%0d exp=32", n); end
      total++; if (es) begin bad++; $display("FAIL fill_error got=1 exp=0"); end
   endtask

   task automatic test_basic_reads();
      logic [31:0] addrs [2];
      logic [31:0] exps [2];
      addrs[0] = 32'h00; addrs[1] = 32'h7C;
      exps[0]  = 32'd0;  exps[1]  = 32'd31;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 4'h0, addrs[i], 32'h0);
         step();
         idle();
         total++; if (read_valid !== 1'b1) begin bad++; $display("FAIL basic_rv addr=%h got=%b exp=1", addrs[i], read_valid); end
         total++; if (result !== exps[i]) begin bad++; $display("FAIL basic_result addr=%h got=%h exp=%h", addrs[i], result, exps[i]); end
         step();
         total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL basic_rv_pulse addr=%h got=%b exp=0", addrs[i], read_valid); end
      end
      model_res = result;
   endtask

   task automatic test_byte_write();
      bit rv; bit er;
      drive(1'b1, 1'b0, 4'b0101, 32'h10, 32'hAABBCCDD);
      model_req(1'b1, 1'b0, 4'b0101, 32'h10, 32'hAABBCCDD, rv, er);
      step();
      total++; if (error !== 1'b0 || read_valid !== 1'b0) begin bad++; $display("FAIL bytewr_flags err=%b rv=%b exp=0,0", error, read_valid); end
      // read on the very next cycle must see the merged word
      drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
      model_req(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, rv, er);
      step();
      total++; if (result !== 32'h00BB00DD) begin bad++; $display("FAIL bytewr_merge got=%h exp=00bb00dd", result); end
      total++; if (model_res !== 32'h00BB00DD) begin bad++; $display("FAIL bytewr_model got=%h exp=00bb00dd", model_res); end
      drive(1'b1, 1'b0, 4'h0, 32'h10, 32'hFFFFFFFF);
      step();
      total++; if (error !== 1'b0) begin bad++; $display("FAIL bytewr_noop_err got=%b exp=0", error); end
      drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
      step();
      idle();
      total++; if (result !== 32'h00BB00DD) begin bad++; $display("FAIL bytewr_noop got=%h exp=00bb00dd", result); end
   endtask

   task automatic test_errors();
      logic [31:0] held;
      logic [31:0] addrs [4];
      bit wrs [4];
      bit rv; bit er;
      addrs[0] = 32'h02; addrs[1] = 32'h80; addrs[2] = 32'h84; addrs[3] = 32'h06;
      wrs[0] = 0; wrs[1] = 0; wrs[2] = 1; wrs[3] = 1;
      held = result;
      for (int i = 0; i < 4; i++) begin
         drive(wrs[i], !wrs[i], 4'hF, addrs[i], 32'hDEADBEEF);
         model_req(wrs[i], !wrs[i], 4'hF, addrs[i], 32'hDEADBEEF, rv, er);
         step();
         idle();
         total++; if (error !== 1'b1) begin bad++; $display("FAIL err_pulse addr=%h got=%b exp=1", addrs[i], error); end
         total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL err_rv addr=%h got=%b exp=0", addrs[i], read_valid); end
         total++; if (result !== held) begin bad++; $display("FAIL err_result addr=%h got=%h exp=%h", addrs[i], result, held); end
         step();
         total++; if (error !== 1'b0) begin bad++; $display("FAIL err_one_cycle addr=%h got=%b exp=0", addrs[i], error); end
      end
      // rejected writes to 0x84/0x06 must not have touched word 1
      drive(1'b0, 1'b1, 4'h0, 32'h04, 32'h0);
      step();
      idle();
      total++; if (result !== model_mem[1]) begin bad++; $display("FAIL err_nowrite got=%h exp=%h", result, model_mem[1]); end
      model_res = result;
   endtask

   task automatic test_write_priority();
      logic [31:0] held;
      bit rv; bit er;
      held = result;
      drive(1'b1, 1'b1, 4'hF, 32'h08, 32'h12345678);
      model_req(1'b1, 1'b1, 4'hF, 32'h08, 32'h12345678, rv, er);
      step();
      total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL prio_rv got=%b exp=0", read_valid); end
      total++; if (result !== held) begin bad++; $display("FAIL prio_result got=%h exp=%h", result, held); end
      drive(1'b0, 1'b1, 4'h0, 32'h08, 32'h0);
      step();
      idle();
      total++; if (result !== 32'h12345678) begin bad++; $display("FAIL prio_readback got=%h exp=12345678", result); end
      model_res = result;
   endtask

   task automatic test_back_to_back();
      bit rv; bit er;
      logic [31:0] a;
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, 31)) * 4;
         drive(1'b0, 1'b1, 4'h0, a, 32'h0);
         model_req(1'b0, 1'b1, 4'h0, a, 32'h0, rv, er);
         step();
         total++; if (read_valid !== 1'b1) begin bad++; $display("FAIL b2b_rv i=%0d got=%b exp=1", i, read_valid); end
         total++; if (result !== model_res) begin bad++; $display("FAIL b2b_result i=%0d got=%h exp=%h", i, result, model_res); end
      end
      idle();
   endtask

   task automatic test_random();
      bit wr; bit rd; bit rv; bit er;
      logic [3:0] be;
      logic [31:0] a; logic [31:0] d;
      for (int i = 0; i < 400; i++) begin
         wr = $urandom_range(0, 2) == 0;
         rd = $urandom_range(0, 1) == 1;
         be = 4'($urandom);
         a  = rand_addr();
         d  = $urandom;
         drive(wr, rd, be, a, d);
         model_req(wr, rd, be, a, d, rv, er);
         step();
         total++; if (read_valid !== rv) begin bad++; $display("FAIL rand_rv i=%0d got=%b exp=%b", i, read_valid, rv); end
         total++; if (error !== er) begin bad++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, error, er); end
         total++; if (result !== model_res) begin bad++; $display("FAIL rand_result i=%0d got=%h exp=%h", i, result, model_res); end
      end
      idle();
   endtask

   task automatic test_readback();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, 4'h0, 32'(i * 4), 32'h0);
         step();
         total++; if (read_valid !== 1'b1 || result !== model_mem[i]) begin
            bad++; $display("FAIL readback word=%0d rv=%b got=%h exp=%h", i, read_valid, result, model_mem[i]);
         end
      end
      idle();
      model_res = result;
   endtask

   task automatic test_reset_mid_init();
      int n; bit es; bit rs;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (ready !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL midinit_pre i=%0d ready=%b err=%b exp=0,0", i, ready, error); end
      end
      rst = 1'b1;
      step();
      total++; if (ready !== 1'b0 || result !== 32'h0) begin bad++; $display("FAIL midinit_rst ready=%b result=%h exp=0,0", ready, result); end
      rst = 1'b0;
      run_fill(1'b0, n, es, rs);
      total++; if (n !== 32) begin bad++; $display("FAIL midinit_cycles got=%0d exp=32", n); end
      total++; if (es) begin bad++; $display("FAIL midinit_error got=1 exp=0"); end
   endtask

   task automatic test_reset_inflight();
      drive(1'b0, 1'b1, 4'h0, 32'h7C, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      total++; if (result !== 32'h0 || read_valid !== 1'b0) begin bad++; $display("FAIL inflight_async result=%h rv=%b exp=0,0", result, read_valid); end
      step();
      total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL inflight_rv got=%b exp=0", read_valid); end
      idle();
   endtask

   task automatic test_requests_during_init();
      int n; bit es; bit rs;
      rst = 1'b0;
      run_fill(1'b1, n, es, rs);
      total++; if (n !== 32) begin bad++; $display("FAIL noisy_cycles got=%0d exp=32", n); end
      total++; if (es) begin bad++; $display("FAIL noisy_error got=1 exp=0"); end
      total++; if (rs) begin bad++; $display("FAIL noisy_rv got=1 exp=0"); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'(i);
      test_reset();
      test_init_fill();
      test_basic_reads();
      test_byte_write();
      test_errors();
      test_write_priority();
      test_back_to_back();
      test_random();
      test_reset_mid_init();
      test_readback();
      test_random();
      test_reset_inflight();
      test_requests_during_init();
      test_readback();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
